// File: rtl/comb_vector_sequencer_if.sv
// Bus between the vector sequencer and the combinational circuit under test.
// Also carries the start/status handshake so one bundle covers the whole block.
interface comb_vector_sequencer_if;
   logic        start;
   logic [1:0]  userinput;
   logic [3:0]  d;
   logic        I;
   logic        a0;
   logic        a1;
   logic        a;
   logic        b;
   logic        c;
   logic [11:0] y;
   logic [1:0]  s;
   logic        x;
   logic        sum;
   logic        carry;
   logic        busy;
   logic        done;
   logic        pass;
   logic [4:0]  err_count;
   logic [3:0]  fail_idx;
   logic        fail_valid;

   // Sequencer side: drives the circuit inputs and reports status.
   modport master (
      input  start, y, s, x, sum, carry,
      output userinput, d, I, a0, a1, a, b, c,
      output busy, done, pass, err_count, fail_idx, fail_valid
   );

   // Circuit/host side: answers the vectors and raises start.
   modport slave (
      output start, y, s, x, sum, carry,
      input  userinput, d, I, a0, a1, a, b, c,
      input  busy, done, pass, err_count, fail_idx, fail_valid
   );
endinterface

// File: rtl/comb_vector_sequencer.sv
// Sweeps the combinational circuit through 16 fixed vectors (encoder/demux,
// decoder/mux, decoder/full adder), waits a settle time per vector, samples
// the responses and compares them against a built-in golden model.
module comb_vector_sequencer #(
   parameter int unsigned SETTLE_CYC = 4,
   parameter logic [3:0]  MUX_DATA   = 4'b0110
) (
   input logic                     clk,
   input logic                     rst,
   comb_vector_sequencer_if.master bus
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, FINISH} SeqState;

   SeqState     state;
   logic [3:0]  vIdx;
   logic [3:0]  settleCnt;
   logic [11:0] yReg;
   logic [1:0]  sReg;
   logic        xReg;
   logic        sumReg;
   logic        carryReg;

   logic [1:0]  driveMode;
   logic [3:0]  driveD;
   logic        driveI;
   logic [1:0]  driveSel;
   logic [2:0]  driveIdx;
   logic        expSum;
   logic        expCarry;
   logic        vecMismatch;

   // Decode the current vector index into drive values and judge the sampled
   // responses; any number of bad fields in one vector is a single mismatch.
   always_comb begin
      driveMode   = 2'd0;
      driveD      = 4'd0;
      driveI      = 1'b0;
      driveSel    = 2'd0;
      driveIdx    = 3'd0;
      expSum      = ^vIdx[2:0];
      expCarry    = (vIdx[2] & vIdx[1]) | (vIdx[2] & vIdx[0]) | (vIdx[1] & vIdx[0]);
      vecMismatch = 1'b0;
      if (vIdx[3:2] == 2'b00) begin
         driveD      = 4'b0001 << vIdx[1:0];
         driveI      = 1'b1;
         vecMismatch = (sReg != vIdx[1:0]) || (yReg[3:0] != (4'b0001 << vIdx[1:0]));
      end else if (vIdx[3:2] == 2'b01) begin
         driveMode   = 2'd1;
         driveD      = MUX_DATA;
         driveSel    = vIdx[1:0];
         vecMismatch = (yReg[11:8] != (4'b0001 << vIdx[1:0])) || (xReg != MUX_DATA[vIdx[1:0]]);
      end else begin
         driveMode   = 2'd2;
         driveIdx    = vIdx[2:0];
         vecMismatch = (yReg[7:0] != (8'b0000_0001 << vIdx[2:0])) ||
                       (sumReg != expSum) || (carryReg != expCarry);
      end
   end

   // Sequencer FSM: input sampling register, vector drive, settle wait,
   // compare and result bookkeeping, all with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         vIdx           <= 4'd0;
         settleCnt      <= 4'd0;
         yReg           <= 12'd0;
         sReg           <= 2'd0;
         xReg           <= 1'b0;
         sumReg         <= 1'b0;
         carryReg       <= 1'b0;
         bus.userinput  <= 2'd0;
         bus.d          <= 4'd0;
         bus.I          <= 1'b0;
         bus.a0         <= 1'b0;
         bus.a1         <= 1'b0;
         bus.a          <= 1'b0;
         bus.b          <= 1'b0;
         bus.c          <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.pass       <= 1'b0;
         bus.err_count  <= 5'd0;
         bus.fail_idx   <= 4'd0;
         bus.fail_valid <= 1'b0;
      end else begin
         yReg     <= bus.y;
         sReg     <= bus.s;
         xReg     <= bus.x;
         sumReg   <= bus.sum;
         carryReg <= bus.carry;
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state          <= LOAD;
                  vIdx           <= 4'd0;
                  bus.busy       <= 1'b1;
                  bus.pass       <= 1'b0;
                  bus.err_count  <= 5'd0;
                  bus.fail_valid <= 1'b0;
               end
            end
            LOAD: begin
               bus.userinput <= driveMode;
               bus.d         <= driveD;
               bus.I         <= driveI;
               bus.a1        <= driveSel[1];
               bus.a0        <= driveSel[0];
               bus.a         <= driveIdx[2];
               bus.b         <= driveIdx[1];
               bus.c         <= driveIdx[0];
               settleCnt     <= SETTLE_LOAD;
               state         <= SETTLE;
            end
            SETTLE: begin
               if (settleCnt == 4'd0) begin
                  state <= CHECK;
               end else begin
                  settleCnt <= settleCnt - 4'd1;
               end
            end
            CHECK: begin
               if (vecMismatch) begin
                  if (bus.err_count != 5'd16) begin
                     bus.err_count <= bus.err_count + 5'd1;
                  end
                  if (!bus.fail_valid) begin
                     bus.fail_idx   <= vIdx;
                     bus.fail_valid <= 1'b1;
                  end
               end
               if (vIdx == 4'd15) begin
                  state <= FINISH;
               end else begin
                  vIdx  <= vIdx + 4'd1;
                  state <= LOAD;
               end
            end
            FINISH: begin
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               bus.pass <= (bus.err_count == 5'd0);
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comb_vector_sequencer.sv
// Bench for comb_vector_sequencer: a behavioural circuit model with
// selectable faults answers the vectors, and each sweep's results and drive
// sequence are checked against expectations derived from the vector list.
module tb_comb_vector_sequencer;

   localparam int         SETTLE_CYC   = 4;
   localparam logic [3:0] MUX_DATA     = 4'b0110;
   localparam int         SWEEP_CYCLES = 16 * (SETTLE_CYC + 2) + 1;

   logic clk = 1'b0;
   logic rst;

   comb_vector_sequencer_if bus();

   comb_vector_sequencer #(.SETTLE_CYC(SETTLE_CYC), .MUX_DATA(MUX_DATA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int testsRun    = 0;
   int testsFailed = 0;
   int sweepCycles;

   // 0 ideal, 1 carry stuck-at-0, 2 s bits swapped, 3 x inverted, 4 random
   int          faultKind = 0;
   logic [15:0] corruptMask = 16'd0;
   int          corruptField [16];
   int          corruptBit [16];
   logic        noiseBit = 1'b0;

   logic [11:0] modelY;
   logic [1:0]  modelS;
   logic        modelX;
   logic        modelSum;
   logic        modelCarry;
   int          modelVec;
   logic [1:0]  sel;
   logic [2:0]  idx;

   // Wiggle bits the golden model must ignore.
   always @(posedge clk) noiseBit <= 1'($urandom);

   // Behavioural circuit: encoder/demux, decoder/mux, decoder/full adder,
   // with optional fault injection keyed on the vector being applied.
   always_comb begin
      modelY     = '0;
      modelS     = '0;
      modelX     = 1'b0;
      modelSum   = 1'b0;
      modelCarry = 1'b0;
      modelVec   = 0;
      sel        = {bus.a1, bus.a0};
      idx        = {bus.a, bus.b, bus.c};
      case (bus.userinput)
         2'd0: begin
            for (int i = 0; i < 4; i++) if (bus.d[i]) modelS = 2'(i);
            modelY[3:0] = bus.d & {4{bus.I}};
            modelY[11]  = noiseBit;
            modelVec    = int'(modelS);
         end
         2'd1: begin
            modelY[11:8] = 4'b0001 << sel;
            modelX       = bus.d[sel];
            modelY[0]    = noiseBit;
            modelVec     = 4 + int'(sel);
         end
         2'd2: begin
            modelY[7:0] = 8'b0000_0001 << idx;
            modelSum    = bus.a ^ bus.b ^ bus.c;
            modelCarry  = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
            modelY[11]  = noiseBit;
            modelVec    = 8 + int'(idx);
         end
         default: modelVec = 0;
      endcase
      case (faultKind)
         1: modelCarry = 1'b0;
         2: modelS = {modelS[0], modelS[1]};
         3: modelX = ~modelX;
         4: begin
            if (corruptMask[modelVec[3:0]]) begin
               if (modelVec < 4) begin
                  if (corruptField[modelVec] % 2 == 0) modelS[corruptBit[modelVec] % 2] = ~modelS[corruptBit[modelVec] % 2];
                  else modelY[corruptBit[modelVec] % 4] = ~modelY[corruptBit[modelVec] % 4];
               end else if (modelVec < 8) begin
                  if (corruptField[modelVec] % 2 == 0) modelY[8 + corruptBit[modelVec] % 4] = ~modelY[8 + corruptBit[modelVec] % 4];
                  else modelX = ~modelX;
               end else begin
                  if (corruptField[modelVec] == 0) modelY[corruptBit[modelVec] % 8] = ~modelY[corruptBit[modelVec] % 8];
                  else if (corruptField[modelVec] == 1) modelSum = ~modelSum;
                  else modelCarry = ~modelCarry;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.y     = modelY;
   assign bus.s     = modelS;
   assign bus.x     = modelX;
   assign bus.sum   = modelSum;
   assign bus.carry = modelCarry;

   logic [11:0] driveLog [$];
   logic [11:0] lastDrive;
   logic [11:0] curDrive;
   logic        prevBusy = 1'b0;

   // Record each distinct drive tuple applied during a sweep.
   always @(negedge clk) begin
      curDrive = {bus.userinput, bus.d, bus.I, bus.a1, bus.a0, bus.a, bus.b, bus.c};
      if (bus.busy && !prevBusy) begin
         driveLog.delete();
         lastDrive = curDrive;
      end else if (bus.busy && curDrive != lastDrive) begin
         driveLog.push_back(curDrive);
         lastDrive = curDrive;
      end
      prevBusy = bus.busy;
   end

   function automatic logic [11:0] expDrive(input int v);
      logic [1:0] mode;
      logic [3:0] dv;
      logic       iv;
      logic [1:0] sv;
      logic [2:0] xv;
      mode = 2'd0; dv = 4'd0; iv = 1'b0; sv = 2'd0; xv = 3'd0;
      if (v < 4) begin
         dv = 4'b0001 << v;
         iv = 1'b1;
      end else if (v < 8) begin
         mode = 2'd1;
         dv   = MUX_DATA;
         sv   = 2'(v - 4);
      end else begin
         mode = 2'd2;
         xv   = 3'(v - 8);
      end
      return {mode, dv, iv, sv, xv};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Pulse start, optionally pulse it again mid-sweep, and wait for done.
   task automatic applyStimulus(input int extraStartAt);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("busyAfterStart", 32'(bus.busy), 32'd1);
      sweepCycles = 0;
      while (!bus.done && sweepCycles < 400) begin
         @(negedge clk);
         sweepCycles++;
         bus.start = (sweepCycles == extraStartAt);
      end
      bus.start = 1'b0;
      checkOutput("sweepCycles", 32'(sweepCycles), 32'(SWEEP_CYCLES));
      @(negedge clk);
      checkOutput("donePulseEnds", 32'(bus.done), 32'd0);
      checkOutput("busyAfterDone", 32'(bus.busy), 32'd0);
   endtask

   task automatic checkResults(input int expErrs, input int expFailIdx);
      checkOutput("pass", 32'(bus.pass), 32'(expErrs == 0));
      checkOutput("errCount", 32'(bus.err_count), 32'(expErrs));
      checkOutput("failValid", 32'(bus.fail_valid), 32'(expErrs != 0));
      if (expErrs != 0) checkOutput("failIdx", 32'(bus.fail_idx), 32'(expFailIdx));
      checkOutput("driveCount", 32'(driveLog.size()), 32'd16);
      for (int v = 0; v < 16 && v < driveLog.size(); v++) begin
         checkOutput($sformatf("drive%0d", v), 32'(driveLog[v]), 32'(expDrive(v)));
      end
   endtask

   task automatic checkResetState();
      checkOutput("rstBusy", 32'(bus.busy), 32'd0);
      checkOutput("rstDone", 32'(bus.done), 32'd0);
      checkOutput("rstPass", 32'(bus.pass), 32'd0);
      checkOutput("rstErrCount", 32'(bus.err_count), 32'd0);
      checkOutput("rstFailIdx", 32'(bus.fail_idx), 32'd0);
      checkOutput("rstFailValid", 32'(bus.fail_valid), 32'd0);
      checkOutput("rstDrive", 32'({bus.userinput, bus.d, bus.I, bus.a1, bus.a0, bus.a, bus.b, bus.c}), 32'd0);
   endtask

   // Main sequence: reset, named fault sweeps, abort and restart, ignored
   // start, then randomized fault sweeps.
   initial begin
      int doneSeen;
      int expErrs;
      int expFirst;
      bus.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkResetState();
      rst = 1'b0;

      faultKind = 0;
      applyStimulus(-1);
      checkResults(0, 0);
      repeat (5) @(negedge clk);
      checkOutput("passHeld", 32'(bus.pass), 32'd1);

      faultKind = 1;
      applyStimulus(-1);
      checkResults(4, 11);

      faultKind = 2;
      applyStimulus(-1);
      checkResults(2, 1);

      faultKind = 3;
      applyStimulus(-1);
      checkResults(4, 4);

      faultKind = 0;
      applyStimulus(-1);
      checkResults(0, 0);

      faultKind = 1;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (57) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkResetState();
      doneSeen = 0;
      repeat (120) begin
         @(negedge clk);
         if (bus.done) doneSeen++;
      end
      checkOutput("noDoneAfterAbort", 32'(doneSeen), 32'd0);
      checkOutput("idleAfterAbort", 32'(bus.busy), 32'd0);
      faultKind = 0;
      applyStimulus(-1);
      checkResults(0, 0);

      faultKind = 3;
      applyStimulus(33);
      checkResults(4, 4);

      faultKind = 4;
      for (int iter = 0; iter < 6; iter++) begin
         corruptMask = 16'($urandom) & 16'($urandom);
         if (iter == 5) corruptMask = 16'hFFFF;
         for (int v = 0; v < 16; v++) begin
            corruptField[v] = int'($urandom_range(0, 2));
            corruptBit[v]   = int'($urandom_range(0, 7));
         end
         expErrs  = $countones(corruptMask);
         expFirst = 0;
         for (int v = 15; v >= 0; v--) if (corruptMask[v]) expFirst = v;
         applyStimulus((iter % 2 == 0) ? int'($urandom_range(2, 90)) : -1);
         checkResults(expErrs, expFirst);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
